tt_checker: RTL

TT_CHECKER -- requirements
Module: tt_checker

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_checker.sv | 111 +++++++++++
 2 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table checker.
package tt_pkg;

    // Default number of inputs of the combinational block under check.
    localparam int unsigned TT_NUM_IN = 4;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } tt_state_t;

endpackage

// File: rtl/tt_checker.sv
// Exhaustive truth-table checker: walks every input vector, gives the
// external combinational block one cycle to settle, compares its output
// against a golden table and reports the mismatch count and first failure.
module tt_checker
    import tt_pkg::*;
#(
    parameter int unsigned            NUM_IN   = TT_NUM_IN,
    parameter logic [2**NUM_IN-1:0]   EXPECTED = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              y,
    output logic [NUM_IN-1:0] vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NUM_IN:0]   err_count,
    output logic [NUM_IN-1:0] first_err
);

    localparam logic [NUM_IN-1:0] IDX_ONE = 1;
    localparam logic [NUM_IN:0]   ERR_ONE = 1;

    tt_state_t         state, state_nxt;
    logic [NUM_IN-1:0] idx;
    logic              clear, advance, check, mismatch;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        check     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_DRIVE;
                    clear     = 1'b1;
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                check = 1'b1;
                if (&idx) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRIVE;
                    advance   = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_DRIVE;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Case inequality so an unknown y is flagged in simulation.
    always_comb begin
        mismatch = (y !== EXPECTED[idx]);
    end

    // Vector index, error counter and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            err_count <= '0;
            first_err <= '0;
        end else if (clear) begin
            idx       <= '0;
            err_count <= '0;
            first_err <= '0;
        end else begin
            if (advance) begin
                idx <= idx + IDX_ONE;
            end
            if (check && mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (err_count == '0) begin
                    first_err <= idx;
                end
            end
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        vec  = idx;
        busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
    end

endmodule
